// File: rtl/cpu_dbg_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_dbg_pkg
// Brief    : Shared types and constants for the core execution controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } ctrl_state_t;

  // ARM "B ." : branch-to-self, the conventional end-of-program idiom
  localparam logic [31:0] HALT_SELF_LOOP = 32'hEAFFFFFE;

endpackage

`default_nettype wire

// File: rtl/rate_divider.sv
//------------------------------------------------------------------------------
// Module   : rate_divider
// Brief    : Modulo-RUN_DIV counter producing a one-clock tick at RUN_DIV-1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rate_divider #(
  parameter int RUN_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int                CW      = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [CW-1:0]     C_LAST  = CW'(RUN_DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == C_LAST);
  assign tick      = en && !clear && w_at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_at_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
//------------------------------------------------------------------------------
// Module   : cpu_step_ctrl
// Brief    : Step/run/breakpoint controller issuing a one-clock core enable.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_step_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int RUN_DIV = 25_000_000,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_pulse,
  input  logic              run_pulse,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  input  logic [31:0]       instr,
  output logic              cpu_en,
  output ctrl_state_t       state,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_next;
  logic             r_cpu_en;
  logic             r_skip_bp;
  logic [CNT_W-1:0] r_instr_count;

  logic             w_tick;
  logic             w_stop_bp;
  logic             w_stop_loop;
  logic             w_issue;
  logic             w_cpu_en_d;
  logic             w_skip_set;

  // Divider is held at zero outside RUN, so every entry starts a full period
  rate_divider #(
    .RUN_DIV (RUN_DIV)
  ) u_rate_divider (
    .clk   (clk),
    .reset (reset),
    .clear (r_state != RUN),
    .en    (r_state == RUN),
    .tick  (w_tick)
  );

  assign w_stop_bp   = bp_en && (pc == bp_addr) && !r_skip_bp;
  assign w_stop_loop = (instr == HALT_SELF_LOOP);

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      IDLE, HALT: begin
        if (run_pulse) begin
          w_next = RUN;
        end else if (step_pulse) begin
          w_next = STEP;
        end
      end
      STEP: begin
        w_next = IDLE;
      end
      RUN: begin
        if (run_pulse) begin
          w_next = IDLE;
        end else if (w_tick) begin
          if (w_stop_bp || w_stop_loop) begin
            w_next = HALT;
          end else begin
            w_issue = 1'b1;
          end
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Enable is registered: it is high during the STEP clock or the clock after a RUN issue
  assign w_cpu_en_d = (w_next == STEP) || w_issue;
  assign w_skip_set = ((r_state == IDLE) || (r_state == HALT)) &&
                      ((w_next == STEP) || (w_next == RUN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cpu_en      <= 1'b0;
      r_skip_bp     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state       <= w_next;
      r_cpu_en      <= w_cpu_en_d;
      r_instr_count <= r_instr_count + CNT_W'(r_cpu_en);
      if (w_skip_set) begin
        r_skip_bp <= 1'b1;
      end else if (r_cpu_en) begin
        r_skip_bp <= 1'b0;
      end
    end
  end

  assign cpu_en      = r_cpu_en;
  assign state       = r_state;
  assign halted      = (r_state == HALT);
  assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_cpu_step_ctrl
// Brief    : Directed bench for cpu_step_ctrl with a simple PC-advancing core model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_step_ctrl;
  import cpu_dbg_pkg::*;

  localparam int RUN_DIV = 4;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             step_pulse = 1'b0;
  logic             run_pulse = 1'b0;
  logic             bp_en = 1'b0;
  logic [31:0]      bp_addr = 32'h0;
  logic [31:0]      pc;
  logic [31:0]      instr;
  logic             loop_en = 1'b0;
  logic             cpu_en;
  ctrl_state_t      state;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];

  cpu_step_ctrl #(
    .RUN_DIV (RUN_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .step_pulse  (step_pulse),
    .run_pulse   (run_pulse),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .instr       (instr),
    .cpu_en      (cpu_en),
    .state       (state),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Minimal core: one instruction per enabled clock, PC += 4
  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= 32'h0;
    else if (cpu_en) pc <= pc + 32'd4;
  end
  assign instr = (loop_en && pc == 32'h8) ? HALT_SELF_LOOP : 32'hE1A00000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed enable must match the next expected cycle/PC
  always @(negedge clk) begin
    if (reset && cpu_en) begin
      chk("en_pending", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("en_cycle", 64'(cyc), 64'(e.cyc));
        chk("en_pc", 64'(pc), 64'(e.pc));
      end
    end
  end

  task automatic push(input int c, input logic [31:0] p);
    exp_t e;
    e.cyc = c;
    e.pc  = p;
    q.push_back(e);
  endtask

  task automatic pulse(input logic r, input logic s);
    run_pulse  = r;
    step_pulse = s;
    @(negedge clk);
    run_pulse  = 1'b0;
    step_pulse = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(state), 64'(IDLE));
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int c;
    int c2;

    // 1: single step
    reset_dut();
    wait_to(10);
    c = cyc;
    push(c + 1, 32'h0);
    pulse(1'b0, 1'b1);
    chk("t1_step_state", 64'(state), 64'(STEP));
    @(negedge clk);
    chk("t1_idle", 64'(state), 64'(IDLE));
    chk("t1_en_low", 64'(cpu_en), 64'd0);
    chk("t1_count", 64'(instr_count), 64'd1);
    drain(4);

    // 2: free run then pause
    reset_dut();
    c = cyc;
    push(c + 5, 32'h0);
    push(c + 9, 32'h4);
    pulse(1'b1, 1'b0);
    chk("t2_run", 64'(state), 64'(RUN));
    wait_to(c + 10);
    pulse(1'b1, 1'b0);
    drain(8);
    chk("t2_idle", 64'(state), 64'(IDLE));
    chk("t2_count", 64'(instr_count), 64'd2);

    // 3: breakpoint halt, then resume executes the breakpointed instruction
    reset_dut();
    bp_en   = 1'b1;
    bp_addr = 32'h0C;
    c = cyc;
    push(c + 5, 32'h0);
    push(c + 9, 32'h4);
    push(c + 13, 32'h8);
    pulse(1'b1, 1'b0);
    wait_to(c + 18);
    chk("t3_halt", 64'(state), 64'(HALT));
    chk("t3_halted", 64'(halted), 64'd1);
    chk("t3_pc", 64'(pc), 64'h0C);
    c2 = cyc;
    push(c2 + 5, 32'h0C);
    push(c2 + 9, 32'h10);
    pulse(1'b1, 1'b0);
    chk("t3_resume_halted", 64'(halted), 64'd0);
    wait_to(c2 + 10);
    pulse(1'b1, 1'b0);
    drain(8);
    chk("t3_idle", 64'(state), 64'(IDLE));
    chk("t3_count", 64'(instr_count), 64'd5);
    chk("t3_pc_end", 64'(pc), 64'h14);
    bp_en = 1'b0;

    // 4: self-loop halt in RUN, step still issues
    reset_dut();
    loop_en = 1'b1;
    c = cyc;
    push(c + 5, 32'h0);
    push(c + 9, 32'h4);
    pulse(1'b1, 1'b0);
    wait_to(c + 14);
    chk("t4_halt", 64'(state), 64'(HALT));
    chk("t4_halted", 64'(halted), 64'd1);
    chk("t4_pc", 64'(pc), 64'h8);
    c2 = cyc;
    push(c2 + 1, 32'h8);
    pulse(1'b0, 1'b1);
    chk("t4_step", 64'(state), 64'(STEP));
    @(negedge clk);
    chk("t4_idle", 64'(state), 64'(IDLE));
    drain(6);
    chk("t4_count", 64'(instr_count), 64'd3);
    chk("t4_pc_end", 64'(pc), 64'hC);
    loop_en = 1'b0;

    // 5: run and step together -> run wins
    reset_dut();
    c = cyc;
    push(c + 5, 32'h0);
    pulse(1'b1, 1'b1);
    chk("t5_run", 64'(state), 64'(RUN));
    chk("t5_no_step_en", 64'(cpu_en), 64'd0);
    wait_to(c + 6);
    pulse(1'b1, 1'b0);
    drain(6);
    chk("t5_count", 64'(instr_count), 64'd1);

    // 5b: pause on the decision clock suppresses that issue
    reset_dut();
    c = cyc;
    push(c + 5, 32'h0);
    pulse(1'b1, 1'b0);
    wait_to(c + 8);
    pulse(1'b1, 1'b0);
    drain(6);
    chk("t5b_idle", 64'(state), 64'(IDLE));
    chk("t5b_count", 64'(instr_count), 64'd1);

    // 6: asynchronous reset while the enable is high
    reset_dut();
    c = cyc;
    push(c + 5, 32'h0);
    pulse(1'b1, 1'b0);
    wait_to(c + 5);
    #2;
    chk("t6_en_before", 64'(cpu_en), 64'd1);
    reset = 1'b0;
    #1;
    chk("t6_en_rst", 64'(cpu_en), 64'd0);
    chk("t6_count_rst", 64'(instr_count), 64'd0);
    chk("t6_state_rst", 64'(state), 64'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    drain(12);
    chk("t6_idle", 64'(state), 64'(IDLE));
    chk("t6_count", 64'(instr_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
